// File: rtl/scan_response_misr_pkg.sv
// Purpose: shared state encoding and default constants for the scan response MISR.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scan_response_misr_pkg;

    // Controller states; encodings are fixed so debug views and the scan controller agree.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        COMPARE = 2'd2
    } state_t;

    // x^16 + x^12 + x^3 + x + 1
    localparam logic [15:0] DEF_POLY = 16'h100B;
    localparam logic [15:0] DEF_SEED = 16'h0000;

    // SCAN_XMASK_EN: when defined, the top gains an xmask input, and masked bits
    // are removed from each shift before injection, so unknown scan cells
    // cannot corrupt the signature.

endpackage

// File: rtl/scan_response_misr_step.sv
// Purpose: next-signature function of the MISR (shift left, polynomial feedback, data inject).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module misr_step
    import scan_response_misr_pkg::*;
#(
    parameter int                    NUM_CHAINS = 4,
    parameter int                    MISR_WIDTH = 16,
    parameter logic [MISR_WIDTH-1:0] POLY       = MISR_WIDTH'(DEF_POLY)
) (
    input  logic [MISR_WIDTH-1:0] sig,
    input  logic [NUM_CHAINS-1:0] inject,
    output logic [MISR_WIDTH-1:0] next_sig
);

    logic [MISR_WIDTH-1:0] inject_ext;
    logic [MISR_WIDTH-1:0] feedback;

    // Shift, fold the outgoing MSB back through the taps, and XOR in the chain bits at the LSBs.
    always_comb begin
        inject_ext                 = '0;
        inject_ext[NUM_CHAINS-1:0] = inject;
        feedback                   = sig[MISR_WIDTH-1] ? POLY : '0;
        next_sig                   = {sig[MISR_WIDTH-2:0], 1'b0} ^ feedback ^ inject_ext;
    end

endmodule

// File: rtl/scan_response_misr.sv
// Purpose: compacts SHIFT_LEN parallel scan-out shifts into a MISR and checks it against golden_sig (SCAN_XMASK_EN adds xmask).
// Latency: done pulses one edge after the last accepted shift; start-to-done is SHIFT_LEN+2 cycles with scan_valid held high.
// Backpressure: none; every scan_valid cycle in COMPACT is consumed, valids in IDLE/COMPARE and starts while busy are dropped.
module scan_response_misr
    import scan_response_misr_pkg::*;
#(
    parameter int                    NUM_CHAINS = 4,
    parameter int                    MISR_WIDTH = 16,
    parameter logic [MISR_WIDTH-1:0] POLY       = MISR_WIDTH'(DEF_POLY),
    parameter logic [MISR_WIDTH-1:0] SEED       = MISR_WIDTH'(DEF_SEED),
    parameter int unsigned           SHIFT_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  scan_valid,
    input  logic [NUM_CHAINS-1:0] scan_data,
`ifdef SCAN_XMASK_EN
    input  logic [NUM_CHAINS-1:0] xmask,
`endif
    input  logic [MISR_WIDTH-1:0] golden_sig,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [MISR_WIDTH-1:0] signature,
    output logic [15:0]           shift_count
);

    // Index of the final shift; shift_count equals this on the edge that takes the last shift.
    localparam logic [15:0] LAST_IDX = 16'(SHIFT_LEN - 1);

    state_t                state;
    logic [NUM_CHAINS-1:0] inject;
    logic [MISR_WIDTH-1:0] next_sig;

`ifdef SCAN_XMASK_EN
    // Masked chain bits are forced to zero so X cells never reach the signature.
    assign inject = scan_data & ~xmask;
`else
    assign inject = scan_data;
`endif

    misr_step #(
        .NUM_CHAINS (NUM_CHAINS),
        .MISR_WIDTH (MISR_WIDTH),
        .POLY       (POLY)
    ) u_misr_step (
        .sig      (signature),
        .inject   (inject),
        .next_sig (next_sig)
    );

    // Run controller: seed on start, fold each valid shift, compare once after the last shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            signature   <= SEED;
            shift_count <= 16'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        signature   <= SEED;
                        shift_count <= 16'd0;
                        pass        <= 1'b0;
                        busy        <= 1'b1;
                        state       <= COMPACT;
                    end
                end
                COMPACT: begin
                    if (scan_valid) begin
                        signature   <= next_sig;
                        shift_count <= shift_count + 16'd1;
                        if (shift_count == LAST_IDX) begin
                            state <= COMPARE;
                        end
                    end
                end
                COMPARE: begin
                    pass  <= (signature == golden_sig);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_response_misr.sv
// Purpose: scoreboard bench for scan_response_misr at SHIFT_LEN 8, 16 and 17.
// Latency: expected done latency is carried with each scoreboard entry.
// Backpressure: n/a.
module tb_scan_response_misr;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        int          lat;
        int          t0;
        int          nsh;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n    = 1'b0;
    logic        start8     = 1'b0;
    logic        start16    = 1'b0;
    logic        start17    = 1'b0;
    logic        scan_valid = 1'b0;
    logic [3:0]  scan_data  = 4'h0;
    logic [15:0] golden_sig = 16'h0000;
`ifdef SCAN_XMASK_EN
    logic [3:0]  xmask      = 4'h0;
`endif

    logic        busy8, done8, pass8;
    logic [15:0] sig8, cnt8;
    logic        busy16, done16, pass16;
    logic [15:0] sig16, cnt16;
    logic        busy17, done17, pass17;
    logic [15:0] sig17, cnt17;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    exp_t q8[$];
    exp_t q16[$];
    exp_t q17[$];

    always @(posedge clk) cyc <= cyc + 1;

    scan_response_misr #(.SHIFT_LEN(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .scan_valid(scan_valid),
        .scan_data(scan_data),
`ifdef SCAN_XMASK_EN
        .xmask(xmask),
`endif
        .golden_sig(golden_sig), .busy(busy8), .done(done8), .pass(pass8),
        .signature(sig8), .shift_count(cnt8)
    );

    scan_response_misr #(.SHIFT_LEN(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .scan_valid(scan_valid),
        .scan_data(scan_data),
`ifdef SCAN_XMASK_EN
        .xmask(xmask),
`endif
        .golden_sig(golden_sig), .busy(busy16), .done(done16), .pass(pass16),
        .signature(sig16), .shift_count(cnt16)
    );

    scan_response_misr #(.SHIFT_LEN(17)) u_dut17 (
        .clk(clk), .reset_n(reset_n), .start(start17), .scan_valid(scan_valid),
        .scan_data(scan_data),
`ifdef SCAN_XMASK_EN
        .xmask(xmask),
`endif
        .golden_sig(golden_sig), .busy(busy17), .done(done17), .pass(pass17),
        .signature(sig17), .shift_count(cnt17)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_done(input string tag, input exp_t e, input logic [15:0] sig,
                              input logic p, input logic b, input logic [15:0] cnt);
        check({tag, "_sig"},   32'(sig),         32'(e.sig));
        check({tag, "_pass"},  32'(p),           32'(e.pass));
        check({tag, "_lat"},   32'(cyc - e.t0),  32'(e.lat));
        check({tag, "_busy"},  32'(b),           32'd0);
        check({tag, "_count"}, 32'(cnt),         32'(e.nsh));
    endtask

    function automatic exp_t mk(input logic [15:0] sig, input logic p, input int lat, input int nsh);
        exp_t e;
        e.sig  = sig;
        e.pass = p;
        e.lat  = lat;
        e.t0   = cyc;
        e.nsh  = nsh;
        return e;
    endfunction

    // Scoreboard pop for each DUT on its done pulse.
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) check("dut8_unexpected_done", 32'(done8), 32'd0);
            else                check_done("dut8", q8.pop_front(), sig8, pass8, busy8, cnt8);
        end
        if (done16) begin
            if (q16.size() == 0) check("dut16_unexpected_done", 32'(done16), 32'd0);
            else                 check_done("dut16", q16.pop_front(), sig16, pass16, busy16, cnt16);
        end
        if (done17) begin
            if (q17.size() == 0) check("dut17_unexpected_done", 32'(done17), 32'd0);
            else                 check_done("dut17", q17.pop_front(), sig17, pass17, busy17, cnt17);
        end
    end

    // Start cycle; scan_valid is held high with junk so the start edge itself must not shift.
    task automatic kick(input bit s8, input bit s16, input bit s17);
        start8     = s8;
        start16    = s16;
        start17    = s17;
        scan_valid = 1'b1;
        scan_data  = 4'hF;
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
        start17 = 1'b0;
    endtask

    // Drive nsh shifts (first carries 'first', rest zero); gapped inserts an idle cycle after each.
    task automatic shifts(input int nsh, input logic [3:0] first, input bit gapped, input bit overrun);
        for (int k = 0; k < nsh; k++) begin
            scan_valid = 1'b1;
            scan_data  = (k == 0) ? first : 4'h0;
            @(negedge clk);
            if (gapped) begin
                scan_valid = 1'b0;
                scan_data  = 4'hF;
                if (k == 2) start8 = 1'b1;
                @(negedge clk);
                start8 = 1'b0;
            end
        end
        if (overrun) begin
            scan_valid = 1'b1;
            scan_data  = 4'hF;
            @(negedge clk);
        end
        scan_valid = 1'b0;
        scan_data  = 4'hF;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q8.size() + q16.size() + q17.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(q8.size() + q16.size() + q17.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy8), 32'd0);
        check("rst_done",  32'(done8), 32'd0);
        check("rst_pass",  32'(pass8), 32'd0);
        check("rst_sig",   32'(sig8),  32'h0000);
        check("rst_count", 32'(cnt8),  32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Three back-to-back contiguous runs on the 8-shift instance.
        golden_sig = 16'h0000;
        q8.push_back(mk(16'h0000, 1'b1, 10, 8));
        kick(1'b1, 1'b0, 1'b0);
        shifts(8, 4'h0, 1'b0, 1'b1);

        golden_sig = 16'h0080;
        q8.push_back(mk(16'h0080, 1'b1, 10, 8));
        kick(1'b1, 1'b0, 1'b0);
        shifts(8, 4'h1, 1'b0, 1'b1);

        golden_sig = 16'h0081;
        q8.push_back(mk(16'h0080, 1'b0, 10, 8));
        kick(1'b1, 1'b0, 1'b0);
        shifts(8, 4'h1, 1'b0, 1'b1);
        wait_idle(40);
        check("pass_held_low", 32'(pass8), 32'd0);

        // Gapped valid, with a start pulse while busy that must be ignored.
        golden_sig = 16'h0080;
        q8.push_back(mk(16'h0080, 1'b1, 17, 8));
        kick(1'b1, 1'b0, 1'b0);
        shifts(8, 4'h1, 1'b1, 1'b0);
        wait_idle(40);
        repeat (3) @(negedge clk);
        check("no_restart_busy", 32'(busy8), 32'd0);
        check("pass_held_high",  32'(pass8), 32'd1);

        // Feedback path: 16 shifts reach the MSB, the 17th folds through the polynomial.
        golden_sig = 16'h8000;
        q16.push_back(mk(16'h8000, 1'b1, 18, 16));
        q17.push_back(mk(16'h100B, 1'b0, 19, 17));
        kick(1'b0, 1'b1, 1'b1);
        shifts(17, 4'h1, 1'b0, 1'b1);
        wait_idle(60);

        // Reset mid-run: run is abandoned, no done must appear.
        kick(1'b1, 1'b0, 1'b0);
        shifts(4, 4'h1, 1'b0, 1'b0);
        check("mid_count", 32'(cnt8), 32'd4);
        check("mid_busy",  32'(busy8), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_busy",  32'(busy8), 32'd0);
        check("arst_sig",   32'(sig8),  32'h0000);
        check("arst_count", 32'(cnt8),  32'd0);
        check("arst_done",  32'(done8), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        golden_sig = 16'h0080;
        q8.push_back(mk(16'h0080, 1'b1, 10, 8));
        kick(1'b1, 1'b0, 1'b0);
        shifts(8, 4'h1, 1'b0, 1'b1);
        wait_idle(40);

`ifdef SCAN_XMASK_EN
        xmask      = 4'h1;
        golden_sig = 16'h0000;
        q8.push_back(mk(16'h0000, 1'b1, 10, 8));
        kick(1'b1, 1'b0, 1'b0);
        shifts(8, 4'h1, 1'b0, 1'b1);
        wait_idle(40);
        xmask = 4'h0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
